// File: rtl/tt_pwm_pkg.sv
// Shared constants and helpers for the PWM microtile family.
// Field positions of the ui_in load word and the stagger offset helper.
package tt_pwm_pkg;

    localparam int STROBE_BIT = 7;
    localparam int SEL_MSB    = 6;
    localparam int SEL_LSB    = 4;
    localparam int NIBBLE_W   = 4;
    localparam int SEL_W      = 3;

    // Phase offset of channel i so rising edges spread evenly over one period.
    function automatic int stagger_off(input int i, input int width, input int channels);
        return (i * (1 << width)) / channels;
    endfunction

endpackage

// File: rtl/tt_sync2_edge.sv
// Parametrised 2-flop synchroniser with a one-cycle rising-edge pulse on one
// selected bit. Asynchronous active-low reset clears every stage.
module tt_sync2_edge #(
    parameter int WIDTH    = 8,
    parameter int EDGE_BIT = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             rise
);

    logic [WIDTH-1:0] meta;
    logic             prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q[EDGE_BIT];
        end
    end

    // High only on the first cycle the synchronised bit is seen set.
    assign rise = q[EDGE_BIT] & ~prev;

endmodule

// File: rtl/tt_um_microtile_pwm_multi.sv
// Multi-channel PWM microtile: nibble-loaded, double-buffered duty registers
// applied at period wrap. Define PWM_STAGGER_EN to phase-spread the channels.
module tt_um_microtile_pwm_multi
    import tt_pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    logic [7:0]          ui_sync;
    logic                strobe_rise;
    logic                load_pulse;
    logic [SEL_W-1:0]    sel;
    logic [NIBBLE_W-1:0] data;
    logic [WIDTH-1:0]    cnt;
    logic                wrap;
    logic [CHANNELS-1:0] pwm_q;

    tt_sync2_edge #(
        .WIDTH    (8),
        .EDGE_BIT (STROBE_BIT)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in),
        .q     (ui_sync),
        .rise  (strobe_rise)
    );

    assign load_pulse = strobe_rise & ui_sync[STROBE_BIT];
    assign sel        = ui_sync[SEL_MSB:SEL_LSB];
    assign data       = ui_sync[NIBBLE_W-1:0];
    assign wrap       = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] shadow;
        logic [WIDTH-1:0] active;
        logic [WIDTH-1:0] cmp;
        logic [WIDTH-1:0] shadow_next;
        logic             pwm_bit;

        // New nibble enters at the bottom; older nibbles shift out the top.
        if (WIDTH > NIBBLE_W) begin : g_shift
            assign shadow_next = {shadow[WIDTH-NIBBLE_W-1:0], data};
        end else begin : g_direct
            assign shadow_next = data[WIDTH-1:0];
        end

`ifdef PWM_STAGGER_EN
        localparam logic [WIDTH-1:0] OFF = WIDTH'(stagger_off(i, WIDTH, CHANNELS));
        assign cmp = cnt + OFF;
`else
        assign cmp = cnt;
`endif

        // Transfer samples the pre-load shadow when a load shares the wrap edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow  <= '0;
                active  <= '0;
                pwm_bit <= 1'b0;
            end else begin
                if (load_pulse && (sel == SEL_W'(i))) begin
                    shadow <= shadow_next;
                end
                if (wrap) begin
                    active <= shadow;
                end
                pwm_bit <= (cmp < active);
            end
        end

        assign pwm_q[i] = pwm_bit;
    end

    for (genvar b = 0; b < 8; b++) begin : g_out
        if (b < CHANNELS) begin : g_used
            assign uo_out[b] = pwm_q[b];
        end else begin : g_tied
            assign uo_out[b] = 1'b0;
        end
    end

endmodule

// File: tb/tb_tt_um_microtile_pwm_multi.sv
// Directed bench for tt_um_microtile_pwm_multi (CHANNELS=4, WIDTH=8):
// table of duty loads with a per-period waveform model, plus corner sequences.
module tb_tt_um_microtile_pwm_multi;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    int checks = 0;
    int errors = 0;
    int cyc;
    int exp_duty [4];

    typedef struct {
        logic [2:0] sel;
        logic [7:0] val;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
    } vec_t;

    vec_t vecs [5];

    tt_um_microtile_pwm_multi #(
        .CHANNELS (4),
        .WIDTH    (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench copy of the period counter: after posedge k, outputs reflect cnt = (k-1) mod 256.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input int ch, input int s);
        int c;
        c = s;
`ifdef PWM_STAGGER_EN
        c = (s + (ch * 256) / 4) % 256;
`endif
        return (c < exp_duty[ch]);
    endfunction

    task automatic load_nibble(input logic [2:0] sel, input logic [3:0] nib);
        @(negedge clk);
        ui_in = {1'b1, sel, nib};
        repeat (4) @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic load_byte(input logic [2:0] sel, input logic [7:0] val);
        load_nibble(sel, val[7:4]);
        load_nibble(sel, val[3:0]);
    endtask

    // Land on the negedge where uo_out reflects cnt = 0.
    task automatic align();
        int g;
        g = 0;
        while ((cyc % 256) != 1 && g < 600) begin
            @(negedge clk);
            g++;
        end
        check("align timeout", int'((cyc % 256) == 1), 1);
    endtask

    task automatic sample_period();
        int mism [4];
        int hi [4];
        int exp_hi [4];
        int upper;
        upper = 0;
        for (int ch = 0; ch < 4; ch++) begin
            mism[ch]   = 0;
            hi[ch]     = 0;
            exp_hi[ch] = 0;
        end
        for (int s = 0; s < 256; s++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (uo_out[ch] !== exp_bit(ch, s)) mism[ch]++;
                if (uo_out[ch] === 1'b1) hi[ch]++;
                if (exp_bit(ch, s)) exp_hi[ch]++;
            end
            if (uo_out[7:4] !== 4'h0) upper++;
            @(negedge clk);
        end
        for (int ch = 0; ch < 4; ch++) begin
            check($sformatf("ch%0d high clks", ch), hi[ch], exp_hi[ch]);
            check($sformatf("ch%0d waveform mismatches", ch), mism[ch], 0);
        end
        check("uo_out[7:4] nonzero clks", upper, 0);
    endtask

    task automatic measure_settled();
        align();
        repeat (256) @(negedge clk);
        sample_period();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nz;
        vecs[0] = '{sel: 3'd1, val: 8'h40, e0: 8'h00, e1: 8'h40, e2: 8'h00, e3: 8'h00};
        vecs[1] = '{sel: 3'd0, val: 8'hFF, e0: 8'hFF, e1: 8'h40, e2: 8'h00, e3: 8'h00};
        vecs[2] = '{sel: 3'd2, val: 8'h00, e0: 8'hFF, e1: 8'h40, e2: 8'h00, e3: 8'h00};
        vecs[3] = '{sel: 3'd3, val: 8'h20, e0: 8'hFF, e1: 8'h40, e2: 8'h00, e3: 8'h20};
        vecs[4] = '{sel: 3'd5, val: 8'h77, e0: 8'hFF, e1: 8'h40, e2: 8'h00, e3: 8'h20};

        for (int ch = 0; ch < 4; ch++) exp_duty[ch] = 0;
        rst_n = 1'b0;
        ui_in = 8'h00;
        repeat (3) @(negedge clk);
        check("uo_out during reset", int'(uo_out), 0);
        rst_n = 1'b1;

        // Idle after reset: nothing may toggle.
        nz = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (uo_out !== 8'h00) nz++;
        end
        check("idle nonzero clks", nz, 0);

        // Table-driven loads, each checked one full period after it settles.
        for (int v = 0; v < 5; v++) begin
            load_byte(vecs[v].sel, vecs[v].val);
            exp_duty[0] = int'(vecs[v].e0);
            exp_duty[1] = int'(vecs[v].e1);
            exp_duty[2] = int'(vecs[v].e2);
            exp_duty[3] = int'(vecs[v].e3);
            measure_settled();
        end

        // Strobe held high for 40 clocks must shift ch0 exactly once: FF -> F3.
        @(negedge clk);
        ui_in = {1'b1, 3'd0, 4'h3};
        repeat (40) @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        exp_duty[0] = 8'hF3;
        measure_settled();

        // ch3 0x20 -> 0x80 loaded early in a period: that period keeps 0x20.
        align();
        fork
            sample_period();
            begin
                repeat (5) @(negedge clk);
                load_byte(3'd3, 8'h80);
            end
        join
        exp_duty[3] = 8'h80;
        sample_period();

        // Asynchronous reset mid-period clears outputs without a clock edge.
        align();
        repeat (10) @(negedge clk);
        check("pre-reset outputs",
              int'(uo_out[3:0]),
              int'({exp_bit(3, 10), exp_bit(2, 10), exp_bit(1, 10), exp_bit(0, 10)}));
        #3;
        rst_n = 1'b0;
        #1;
        check("uo_out right after async reset", int'(uo_out), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int ch = 0; ch < 4; ch++) exp_duty[ch] = 0;
        measure_settled();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
